// File: rtl/fmul_arbiter.sv
// fmul_arbiter: round-robin arbiter and result router sharing one pipelined
// float_mul among NREQ issue lanes.
//
// Each cycle it grants at most one lane, registers that lane's operand pair
// into the multiplier, and tracks the lane through a LAT+1 stage tag pipeline.
// The product is returned to that lane LAT+1 edges after the accept.
//
// Parameters:
//   NREQ       number of requesting lanes (2..8)
//   LAT        float_mul latency in edges from operand change to valid (>= 1)
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; forces req_ready to 0
//   req_valid  per-lane request
//   req_a/b    per-lane operands, lane i at [32*i+31:32*i]
//   req_ready  one-hot grant, combinational from req_valid and the pointer
//   mul_a/b    registered operands to float_mul.num_1/num_2
//   mul_out    product from float_mul.out
//   resp_valid registered one-hot (or zero) response lane
//   resp_data  registered product
// Optional feature (macro FMUL_ARB_PERF_EN):
//   perf_ops   accepted operation count (wraps mod 2^32)
//   perf_stall cycles in which some valid lane was not granted (wraps)

module fmul_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [31:0]          mul_out,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_data
`ifdef FMUL_ARB_PERF_EN
  ,
  output logic [31:0]          perf_ops,
  output logic [31:0]          perf_stall
`endif
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NS = LAT + 1;

  logic [31:0]     a_lane [NREQ];
  logic [31:0]     b_lane [NREQ];

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [31:0]     mul_a_q, mul_a_d;
  logic [31:0]     mul_b_q, mul_b_d;
  logic [NS-1:0]   tag_vld_q, tag_vld_d;
  logic [NREQ-1:0] tag_lane_q [NS];
  logic [NREQ-1:0] tag_lane_d [NS];
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic [31:0]     resp_data_q, resp_data_d;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   scan_idx;
  logic            accept;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_lane[i] = req_a[32*i +: 32];
    assign b_lane[i] = req_b[32*i +: 32];
  end

  // Rotating priority: scan lanes ptr, ptr+1, ... modulo NREQ and take the
  // first valid one. Reset masks the grant so nothing is accepted.
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    scan_idx = '0;
    accept   = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = PW'((32'(ptr_q) + k) % NREQ);
      if (!accept && req_valid[scan_idx]) begin
        accept          = 1'b1;
        grant[scan_idx] = 1'b1;
        gnt_idx         = scan_idx;
      end
    end
    if (rst) begin
      grant  = '0;
      accept = 1'b0;
    end
  end

  assign req_ready = grant;

  always_comb begin
    ptr_d        = ptr_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;

    // Tag pipeline shifts every edge; an idle edge inserts an invalid tag.
    tag_vld_d     = {tag_vld_q[NS-2:0], accept};
    tag_lane_d[0] = grant;
    for (int unsigned s = 1; s < NS; s++) begin
      tag_lane_d[s] = tag_lane_q[s-1];
    end

    if (accept) begin
      ptr_d   = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
      mul_a_d = a_lane[gnt_idx];
      mul_b_d = b_lane[gnt_idx];
    end

    if (tag_vld_q[NS-1]) begin
      resp_valid_d = tag_lane_q[NS-1];
      resp_data_d  = mul_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      tag_vld_q    <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      for (int unsigned s = 0; s < NS; s++) begin
        tag_lane_q[s] <= '0;
      end
    end else begin
      ptr_q        <= ptr_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      tag_vld_q    <= tag_vld_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      for (int unsigned s = 0; s < NS; s++) begin
        tag_lane_q[s] <= tag_lane_d[s];
      end
    end
  end

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

`ifdef FMUL_ARB_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_ops_d   = perf_ops_q + 32'(accept);
    perf_stall_d = perf_stall_q + 32'(|(req_valid & ~grant));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ops_q   <= perf_ops_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: doc/fmul_arbiter.md
# fmul_arbiter

Round-robin arbiter and result router that shares one pipelined `float_mul` unit among `NREQ` VLIW issue lanes. Each cycle it grants at most one lane's operand pair and drives the pair into the multiplier. It tracks the granting lane through a tag pipeline matched to the multiplier latency, then returns the 32-bit IEEE-754 product to that lane only. It sits between the lane issue logic and the single FMUL datapath instance.

## Interface
Parameters:
- `NREQ`, 4: number of requesting lanes, from 2 to 8.
- `LAT`, 2: multiplier latency, in clock edges from operand change to `mul_out` valid; at least 1.

Ports:
- `clk` in 1: single clock; all state on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in `NREQ`: per-lane request.
- `req_a` in `NREQ*32`: lane i operand A at bits `[32*i+31:32*i]`.
- `req_b` in `NREQ*32`: lane i operand B, same packing.
- `req_ready` out `NREQ`: one-hot grant; combinational from `req_valid` and the pointer.
- `mul_a` out 32: registered operand A to `float_mul.num_1`.
- `mul_b` out 32: registered operand B to `float_mul.num_2`.
- `mul_out` in 32: product from `float_mul.out`.
- `resp_valid` out `NREQ`: registered, one-hot or zero; lane i result present.
- `resp_data` out 32: registered product.

## Operation
- Accept: lane i is accepted on an edge where `req_valid[i] & req_ready[i]` is 1. At most one acceptance per edge.
- Grant:
  - Select the first lane with `req_valid` set, searching from `ptr` upward and wrapping modulo `NREQ`.
  - `req_ready` is 0 when no lane is valid.
  - Lanes must not derive `req_valid` from `req_ready`.
- Pointer:
  - On an accept of lane g, `ptr <= (g+1) mod NREQ`.
  - On an idle edge, `ptr` is unchanged.
  - With `NREQ` not a power of two, the wrap goes from `NREQ-1` to 0.
- Operands:
  - On accept, `mul_a`/`mul_b` load the granted lane's `req_a`/`req_b`.
  - On idle edges they hold their value.
- Tag pipeline:
  - `LAT`+1 stages, each holding a `valid` bit and an `NREQ`-bit one-hot lane field.
  - Stage 0 is loaded on the accept edge.
  - Each edge shifts the pipeline one stage.
  - An idle edge inserts `valid=0`.
- Response:
  - When the last stage is valid, `resp_valid` is set to its one-hot lane field on the next edge and `resp_data` loads `mul_out`.
  - Otherwise `resp_valid` is set to 0 and `resp_data` holds.
- No response backpressure: the lane must consume `resp_data` in the cycle `resp_valid[i]` is high.
- Arithmetic: the block passes all 32-bit values unmodified. Sign, exponent and exceptions are handled entirely inside `float_mul`.

## Timing
- Reset values:
  - `mul_a`, `mul_b`, `resp_data`: 0.
  - `resp_valid`: 0.
  - `ptr`: 0.
  - All tag-pipeline `valid` bits: 0.
  - `req_ready` is whatever the grant logic gives from `req_valid` with `ptr`=0.
- Latency:
  - If lane i is accepted on edge E, `resp_valid[i]` and `resp_data` are valid in the cycle after edge E+LAT+1.
  - `mul_a`/`mul_b` change at E.
  - `mul_out` is valid after E+LAT and is captured at E+LAT+1.
- Throughput: one operation per cycle sustained, with back-to-back grants to any lane mix.
- Simultaneous requests from all lanes: each lane is granted exactly once every `NREQ` cycles, in ascending order starting at `ptr`.
- Reset mid-operation:
  - In-flight operations are dropped.
  - No `resp_valid` is produced for them after `rst` deasserts.
  - Stale contents of the `float_mul` pipeline are ignored because all tags are cleared.
- While `rst` is high, acceptance is suppressed: `req_ready` is forced to 0.

## Configuration
- Macro: `FMUL_ARB_PERF_EN`.
- Defined:
  - Adds output `perf_ops` (32 bits), which counts accepted operations.
  - Adds output `perf_stall` (32 bits), which counts cycles in which any `req_valid` lane was not granted.
  - Both counters reset to 0 and wrap modulo 2^32.
- Undefined: both ports and counters are absent, with no other behavioural difference.

## Test plan
- Single op: lane 0 sends 0x3FC00000 × 0x40000000 (1.5 × 2.0) -> `resp_valid`=0001 and `resp_data`=0x40400000, `LAT`+1 edges after accept; no other response.
- Sign: lane 2 sends 0xC0000000 × 0x3F000000 (−2.0 × 0.5) -> `resp_valid`=0100 and `resp_data`=0xBF800000.
- Fairness:
  - All 4 lanes hold valid for 8 cycles from reset.
  - Required grant order: 0,1,2,3,0,1,2,3.
  - Each response returns to the matching lane in the same order, one per cycle.
- Wrap/skip:
  - `ptr`=3 and only lanes 1 and 3 are valid -> grant 3, then 1, then 3.
  - `NREQ`=3: `ptr` wraps from 2 to 0.
- Reset mid-flight:
  - Accept lanes 0 and 1, then assert `rst` one cycle later for 1 cycle.
  - Required: no `resp_valid` for either operation afterwards; all outputs 0; `ptr`=0.
- Perf (`FMUL_ARB_PERF_EN`): 4 lanes valid for 4 cycles -> `perf_ops`=4, `perf_stall`=4.
